mac_tap_sched: RTL and testbench

- Sequencer for the 5-tap 8-bit multiply-accumulate datapath (`mac`, 16-bit result).
- Holds the coefficient bank c1..c5, which is written over a config port.
- Builds a sliding window of input samples A1..A5 from a valid/ready stream.
- Issues one MAC operation per full window, captures the result after a fixed datapath latency, and presents it on a valid/ready output.
- Sits between the sample source and the `mac` instance; the `mac` itself has no flow control.

---
 rtl/mac_tap_sched_pkg.sv | 19 +
 rtl/mac_tap_sched_if.sv | 26 ++
 rtl/mac_tap_sched_window.sv | 30 +++
 rtl/mac_tap_sched.sv | 149 ++++++++++++++
 tb/tb_mac_tap_sched.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_tap_sched_pkg.sv
// Shared types and sizing for the MAC tap sequencer.
// Optional feature macro used elsewhere: MAC_TAP_SCHED_CNT_EN.
package mac_tap_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int TAPS   = 5;
  localparam int CNT_W  = $clog2(TAPS + 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    WAIT,
    HOLD,
    SLIDE
  } state_t;

endpackage

// File: rtl/mac_tap_sched_if.sv
// Sample stream, result stream and datapath bus of the MAC tap sequencer.
interface mac_tap_sched_if;
  import mac_tap_pkg::*;

  logic [DATA_W-1:0]      s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic [TAPS*DATA_W-1:0] mac_a;
  logic [TAPS*DATA_W-1:0] mac_c;
  logic                   mac_en;
  logic [ACC_W-1:0]       mac_result;
  logic [ACC_W-1:0]       r_data;
  logic                   r_valid;
  logic                   r_ready;

  modport slave (
    input  s_data, s_valid, mac_result, r_ready,
    output s_ready, mac_a, mac_c, mac_en, r_data, r_valid
  );

  modport master (
    output s_data, s_valid, mac_result, r_ready,
    input  s_ready, mac_a, mac_c, mac_en, r_data, r_valid
  );

endinterface

// File: rtl/mac_tap_sched_window.sv
// TAPS-deep sample shift register; slot 0 holds the newest sample at the LSBs.
module mac_tap_window
  import mac_tap_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_shift,
  input  logic [DATA_W-1:0]      i_data,
  output logic [TAPS*DATA_W-1:0] o_win
);

  logic [DATA_W-1:0] r_tap [TAPS];

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      for (int i = 0; i < TAPS; i++) r_tap[i] <= '0;
    end else if (i_shift) begin
      r_tap[0] <= i_data;
      for (int i = 1; i < TAPS; i++) r_tap[i] <= r_tap[i-1];
    end
  end

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_flat
      assign o_win[gi*DATA_W +: DATA_W] = r_tap[gi];
    end
  endgenerate

endmodule

// File: rtl/mac_tap_sched.sv
// Sequencer for a TAPS-wide MAC datapath: coefficient bank, sliding window, issue/capture FSM.
// Define MAC_TAP_SCHED_CNT_EN to add the res_count handshake counter output.
module mac_tap_sched
  import mac_tap_pkg::*;
#(
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
`ifdef MAC_TAP_SCHED_CNT_EN
  output logic [15:0]       res_count,
`endif
  output logic              busy,
  mac_tap_sched_if.slave    bus
);

  localparam logic [2:0]       TAPS_A   = 3'(TAPS);
  localparam logic [CNT_W-1:0] FILL_END = CNT_W'(TAPS - 1);
  localparam logic [2:0]       LAT_LOAD = 3'(MAC_LAT - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_fill;
  logic [2:0]        r_lat;
  logic [DATA_W-1:0] r_coef [TAPS];
  logic              r_s_ready;
  logic              r_mac_en;
  logic              r_res_valid;
  logic              r_busy;
  logic [ACC_W-1:0]  r_res;

  wire w_accept = bus.s_valid && r_s_ready;
  wire w_clr    = (r_state == IDLE) && enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
    end else if ((r_state == IDLE) && cfg_we && (cfg_addr < TAPS_A)) begin
      r_coef[cfg_addr] <= cfg_data;
    end
  end

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
      assign bus.mac_c[gi*DATA_W +: DATA_W] = r_coef[gi];
    end
  endgenerate

  mac_tap_window u_window (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_shift (w_accept),
    .i_data  (bus.s_data),
    .o_win   (bus.mac_a)
  );

  // Outputs are registered alongside the state so they change exactly with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_fill      <= '0;
      r_lat       <= '0;
      r_s_ready   <= 1'b0;
      r_mac_en    <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_res       <= '0;
    end else begin
      r_mac_en <= 1'b0;
      unique case (r_state)
        IDLE: if (enable) begin
          r_state   <= FILL;
          r_fill    <= '0;
          r_s_ready <= 1'b1;
          r_busy    <= 1'b1;
        end
        FILL: if (w_accept) begin
          r_fill <= r_fill + 1'b1;
          if (r_fill == FILL_END) begin
            r_state   <= ISSUE;
            r_s_ready <= 1'b0;
            r_mac_en  <= 1'b1;
          end
        end else if (!enable) begin
          r_state   <= IDLE;
          r_s_ready <= 1'b0;
          r_busy    <= 1'b0;
        end
        ISSUE: begin
          r_state <= WAIT;
          r_lat   <= LAT_LOAD;
        end
        WAIT: if (r_lat == 3'd0) begin
          r_res       <= bus.mac_result;
          r_res_valid <= 1'b1;
          r_state     <= HOLD;
        end else begin
          r_lat <= r_lat - 3'd1;
        end
        HOLD: if (bus.r_ready) begin
          r_res_valid <= 1'b0;
          if (enable) begin
            r_state   <= SLIDE;
            r_s_ready <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        SLIDE: if (w_accept) begin
          r_state   <= ISSUE;
          r_s_ready <= 1'b0;
          r_mac_en  <= 1'b1;
        end else if (!enable) begin
          r_state   <= IDLE;
          r_s_ready <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_s_ready <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAC_TAP_SCHED_CNT_EN
  logic [15:0] r_res_count;

  always_ff @(posedge clk) begin
    if (rst) r_res_count <= '0;
    else if (r_res_valid && bus.r_ready) r_res_count <= r_res_count + 16'd1;
  end

  assign res_count = r_res_count;
`endif

  assign bus.s_ready = r_s_ready;
  assign bus.mac_en  = r_mac_en;
  assign bus.r_data  = r_res;
  assign bus.r_valid = r_res_valid;
  assign busy        = r_busy;

endmodule

// File: tb/tb_mac_tap_sched.sv
// Directed bench for mac_tap_sched with a behavioural sum-of-products MAC of latency MAC_LAT.
module tb_mac_tap_sched;
  import mac_tap_pkg::*;

  localparam int MAC_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              busy;
`ifdef MAC_TAP_SCHED_CNT_EN
  logic [15:0]       res_count;
`endif

  mac_tap_sched_if bus ();

  mac_tap_sched #(.MAC_LAT(MAC_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
`ifdef MAC_TAP_SCHED_CNT_EN
    .res_count(res_count),
`endif
    .busy     (busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: sum of products registered on mac_en, then delayed.
  logic [ACC_W-1:0] sop;
  logic [ACC_W-1:0] pipe [MAC_LAT];

  always_comb begin
    sop = '0;
    for (int k = 0; k < TAPS; k++)
      sop = sop + ACC_W'(bus.mac_a[k*DATA_W +: DATA_W] * bus.mac_c[k*DATA_W +: DATA_W]);
  end

  always @(posedge clk) begin
    if (bus.mac_en) pipe[0] <= sop;
    for (int k = 1; k < MAC_LAT; k++) pipe[k] <= pipe[k-1];
  end

  assign bus.mac_result = pipe[MAC_LAT-1];

  int en_cnt  = 0;
  int acc_cnt = 0;

  always @(posedge clk) begin
    if (bus.mac_en) en_cnt <= en_cnt + 1;
    if (bus.s_valid && bus.s_ready) acc_cnt <= acc_cnt + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input logic [2:0] addr, input logic [7:0] data);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
    $display("cfg write addr=%0d data=%0d mac_c=%h", addr, data, bus.mac_c);
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.s_ready) check("send_timeout", 0, 1);
    tick();
    bus.s_valid = 1'b0;
    $display("sample %0d sent, mac_a=%h", d, bus.mac_a);
  endtask

  task automatic wait_result(input string tag, input logic [15:0] exp);
    int n = 0;
    while (!bus.r_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, bus.r_valid, 1);
    check(tag, bus.r_data, exp);
    $display("result %s r_data=%0d", tag, bus.r_data);
  endtask

  int en0, acc0;
  logic seen_valid;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    bus.s_data = '0; bus.s_valid = 1'b0; bus.r_ready = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_r_valid", bus.r_valid, 0);
    check("rst_r_data", bus.r_data, 0);
    check("rst_mac_c", bus.mac_c, 0);
    check("rst_mac_en", bus.mac_en, 0);
    rst = 1'b0;
    tick();

    // Basic flow: unit coefficients, unit samples.
    for (int i = 0; i < TAPS; i++) wr_coef(3'(i), 8'd1);
    en0 = en_cnt;
    enable = 1'b1;
    tick();
    check("fill_busy", busy, 1);
    check("fill_s_ready", bus.s_ready, 1);
    for (int i = 0; i < TAPS; i++) send(8'd1);
    check("t1_issue_en", bus.mac_en, 1);
    check("t1_issue_busy", busy, 1);
    tick();
    check("t1_wait_en", bus.mac_en, 0);
    check("t1_wait_valid", bus.r_valid, 0);
    tick();
    check("t1_hold_valid", bus.r_valid, 1);
    check("t1_r_data", bus.r_data, 5);
    enable = 1'b0;
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    check("t1_drop_valid", bus.r_valid, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_en_pulses", en_cnt - en0, 1);

    // Weighted sum and ordering.
    for (int i = 0; i < TAPS; i++) wr_coef(3'(i), 8'(i + 1));
    check("t2_mac_c", bus.mac_c, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    enable = 1'b1;
    tick();
    for (int i = 1; i <= TAPS; i++) send(8'(10 * i));
    check("t2_issue_en", bus.mac_en, 1);
    check("t2_window", bus.mac_a, {8'd10, 8'd20, 8'd30, 8'd40, 8'd50});
    wait_result("t2_r_data", 16'd350);

    // Back-pressure: result held, no sample taken, no new issue.
    en0 = en_cnt;
    bus.s_data  = 8'd60;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_r_valid", bus.r_valid, 1);
      check("bp_r_data", bus.r_data, 350);
      check("bp_s_ready", bus.s_ready, 0);
      tick();
    end
    check("bp_en_pulses", en_cnt - en0, 0);
    $display("back-pressure 10 cycles held r_data=%0d", bus.r_data);

    // Sliding window: one sample between results.
    acc0 = acc_cnt;
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    check("slide_s_ready", bus.s_ready, 1);
    tick();
    bus.s_valid = 1'b0;
    check("slide_issue_en", bus.mac_en, 1);
    check("slide_window", bus.mac_a, {8'd20, 8'd30, 8'd40, 8'd50, 8'd60});
    wait_result("t3_r_data", 16'd500);
    check("slide_accepts", acc_cnt - acc0, 1);
    enable = 1'b0;
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    check("t3_idle_busy", busy, 0);

    // Config lockout outside IDLE and out-of-range address.
    enable = 1'b1;
    tick();
    wr_coef(3'd0, 8'd9);
    check("lock_fill_mac_c", bus.mac_c, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    enable = 1'b0;
    tick();
    check("lock_idle_busy", busy, 0);
    wr_coef(3'd6, 8'd9);
    check("bad_addr6_mac_c", bus.mac_c, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    wr_coef(3'd5, 8'd9);
    check("bad_addr5_mac_c", bus.mac_c, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1});

    // Reset while waiting on the datapath.
    enable = 1'b1;
    tick();
    for (int i = 1; i <= TAPS; i++) send(8'(i));
    tick();
    check("rw_wait_busy", busy, 1);
    check("rw_wait_valid", bus.r_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    enable = 1'b0;
    bus.r_ready = 1'b1;
    check("rw_busy", busy, 0);
    check("rw_r_valid", bus.r_valid, 0);
    check("rw_mac_c", bus.mac_c, 0);
    check("rw_s_ready", bus.s_ready, 0);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.r_valid) seen_valid = 1'b1;
    end
    check("rw_no_result", seen_valid, 0);
    $display("reset in WAIT: no result emitted");

`ifdef MAC_TAP_SCHED_CNT_EN
    check("cnt_after_rst", res_count, 0);
    enable = 1'b1;
    tick();
    for (int i = 0; i < TAPS; i++) send(8'd3);
    wait_result("cnt_r1", 16'd0);
    tick();
    send(8'd7);
    wait_result("cnt_r2", 16'd0);
    enable = 1'b0;
    tick();
    check("cnt_two", res_count, 2);
    $display("res_count=%0d", res_count);
`endif

    bus.r_ready = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
